// File: rtl/result_dump.sv
`default_nettype none
// ============================================================================
// Module      : result_dump
// Description : Freezes the core on ECALL, then streams a data-memory window
//               out as a framed byte stream (header, LE words, XOR checksum).
// Revision    : 1.0 - initial release
// ============================================================================
module result_dump #(
    parameter int         ADDR_WIDTH   = 8,
    parameter int         START_ADDR   = 0,
    parameter int         NUM_WORDS    = 8,
    parameter logic [6:0] ECALL_OPCODE = 7'b1110011,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    output logic                  halt,
    output logic                  dmem_rd_en,
    output logic [ADDR_WIDTH-1:0] dmem_rd_addr,
    input  logic [31:0]           dmem_rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_HDR  = 3'd1;
    localparam logic [2:0] c_REQ  = 3'd2;
    localparam logic [2:0] c_WAIT = 3'd3;
    localparam logic [2:0] c_SEND = 3'd4;
    localparam logic [2:0] c_CSUM = 3'd5;
    localparam logic [2:0] c_DONE = 3'd6;

    localparam int                    c_IDX_W = $clog2(NUM_WORDS + 1) + 1;
    localparam logic [c_IDX_W-1:0]    c_NUM   = c_IDX_W'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] c_START = ADDR_WIDTH'(START_ADDR);

    logic [2:0]            r_state;
    logic                  r_halt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic [c_IDX_W-1:0]    r_index;
    logic [1:0]            r_k;
    logic [23:0]           r_shift;
    logic [7:0]            r_csum;

    logic                  w_fire;
    logic                  w_trigger;
    logic [c_IDX_W-1:0]    w_index_next;
    logic                  w_unused_instr;

    assign w_fire         = r_tx_valid && tx_ready;
    assign w_trigger      = (instr[6:0] == ECALL_OPCODE);
    assign w_index_next   = r_index + c_IDX_W'(1);
    assign w_unused_instr = ^instr[31:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_halt     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_index    <= '0;
            r_k        <= 2'd0;
            r_shift    <= 24'h0;
            r_csum     <= 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_trigger) begin
                        r_state    <= c_HDR;
                        r_halt     <= 1'b1;
                        r_busy     <= 1'b1;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= HEADER_BYTE;
                        r_index    <= '0;
                        r_k        <= 2'd0;
                        r_csum     <= 8'h00;
                        r_rd_addr  <= c_START;
                    end
                end
                c_HDR: begin
                    if (w_fire) begin
                        if (NUM_WORDS > 0) begin
                            r_state    <= c_REQ;
                            r_rd_en    <= 1'b1;
                            r_tx_valid <= 1'b0;
                        end else begin
                            // Empty window: the checksum byte follows the header directly.
                            r_state   <= c_CSUM;
                            r_tx_data <= r_csum;
                        end
                    end
                end
                c_REQ: begin
                    r_rd_en <= 1'b0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    r_tx_data  <= dmem_rd_data[7:0];
                    r_shift    <= dmem_rd_data[31:8];
                    r_tx_valid <= 1'b1;
                    r_k        <= 2'd0;
                    r_state    <= c_SEND;
                end
                c_SEND: begin
                    if (w_fire) begin
                        r_csum <= r_csum ^ r_tx_data;
                        if (r_k != 2'd3) begin
                            r_k       <= r_k + 2'd1;
                            r_tx_data <= r_shift[7:0];
                            r_shift   <= {8'h00, r_shift[23:8]};
                        end else begin
                            r_index   <= w_index_next;
                            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                            if (w_index_next < c_NUM) begin
                                r_state    <= c_REQ;
                                r_rd_en    <= 1'b1;
                                r_tx_valid <= 1'b0;
                            end else begin
                                // Fold in the last data byte on the way to the checksum.
                                r_state   <= c_CSUM;
                                r_tx_data <= r_csum ^ r_tx_data;
                            end
                        end
                    end
                end
                c_CSUM: begin
                    if (w_fire) begin
                        r_state    <= c_DONE;
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_DONE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign halt         = r_halt;
    assign busy         = r_busy;
    assign done         = r_done;
    assign dmem_rd_en   = r_rd_en;
    assign dmem_rd_addr = r_rd_addr;
    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_result_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_dump
// Description : Self-checking bench for result_dump: vector table, random
//               memory/backpressure against a frame model, corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_dump;

    localparam logic [6:0] c_ECALL = 7'b1110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] instr0 = 32'h0, instr1 = 32'h0, instr2 = 32'h0;
    logic        tx_ready = 1'b0;

    logic        halt0, rd_en0, txv0, busy0, done0;
    logic [7:0]  addr0, txd0;
    logic [31:0] rdata0;
    logic        halt1, rd_en1, txv1, busy1, done1;
    logic [2:0]  addr1;
    logic [7:0]  txd1;
    logic [31:0] rdata1;
    logic        halt2, rd_en2, txv2, busy2, done2;
    logic [7:0]  addr2, txd2;
    logic [31:0] rdata2;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [8];

    // Read data is only meaningful the cycle after the strobe; garbage otherwise.
    always @(posedge clk) rdata0 <= rd_en0 ? mem0[addr0] : $urandom;
    always @(posedge clk) rdata1 <= rd_en1 ? mem1[addr1] : $urandom;
    always @(posedge clk) rdata2 <= $urandom;

    result_dump u_dut0 (
        .clk(clk), .rst(rst), .instr(instr0), .halt(halt0), .dmem_rd_en(rd_en0),
        .dmem_rd_addr(addr0), .dmem_rd_data(rdata0), .tx_data(txd0), .tx_valid(txv0),
        .tx_ready(tx_ready), .busy(busy0), .done(done0)
    );

    result_dump #(.ADDR_WIDTH(3), .START_ADDR(6), .NUM_WORDS(4)) u_dut1 (
        .clk(clk), .rst(rst), .instr(instr1), .halt(halt1), .dmem_rd_en(rd_en1),
        .dmem_rd_addr(addr1), .dmem_rd_data(rdata1), .tx_data(txd1), .tx_valid(txv1),
        .tx_ready(tx_ready), .busy(busy1), .done(done1)
    );

    result_dump #(.NUM_WORDS(0)) u_dut2 (
        .clk(clk), .rst(rst), .instr(instr2), .halt(halt2), .dmem_rd_en(rd_en2),
        .dmem_rd_addr(addr2), .dmem_rd_data(rdata2), .tx_data(txd2), .tx_valid(txv2),
        .tx_ready(tx_ready), .busy(busy2), .done(done2)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle0(input string name);
        check({name, "_ctl"}, {27'h0, halt0, rd_en0, txv0, busy0, done0}, 32'h0);
        check({name, "_addr"}, {24'h0, addr0}, 32'h0);
        check({name, "_txd"}, {24'h0, txd0}, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; instr0 = 32'h0; instr1 = 32'h0; instr2 = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle0("reset");
    endtask

    // Frame as the host should see it: header, each word LE, XOR of data bytes.
    task automatic build_exp(input int start, input int nwords, input int amod, input bit use_mem1);
        logic [7:0]  cs;
        logic [31:0] w;
        exp_q = {};
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int i = 0; i < nwords; i++) begin
            w = use_mem1 ? mem1[(start + i) % amod] : mem0[(start + i) % amod];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic fill_mem0(input int kind);
        for (int i = 0; i < 256; i++) mem0[i] = $urandom;
        if (kind == 0 || kind == 1) begin
            for (int i = 0; i < 8; i++) mem0[i] = 32'h0;
            mem0[7] = (kind == 0) ? 32'd20 : 32'd12500;
        end
    endtask

    task automatic run_dump0(input int mode, input int hold, input int exp_csum, input int exp_lat);
        logic [7:0] got_q[$];
        int         halt_at, done_at, nrd, c;
        logic       stall;
        logic [7:0] stall_data;
        halt_at = -1; done_at = -1; nrd = 0; c = 0; stall = 1'b0; stall_data = 8'h00;
        build_exp(0, 8, 256, 1'b0);
        while (done_at < 0 && c < 2000) begin
            @(posedge clk); #1;
            instr0   = (c < hold) ? {25'($urandom), c_ECALL} : $urandom;
            tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 4) == 0 || (c % 4) == 3) : 1'($urandom);
            @(negedge clk);
            if (halt0 && halt_at < 0) halt_at = c;
            if (stall) check("stall_hold", {23'h0, txv0, txd0}, {23'h0, 1'b1, stall_data});
            if (halt_at >= 0 && !done0) check("busy_in_frame", {30'h0, halt0, busy0}, 32'h3);
            if (rd_en0) begin
                check("rd_addr", {24'h0, addr0}, nrd);
                nrd++;
            end
            if (txv0 && tx_ready) got_q.push_back(txd0);
            stall      = txv0 && !tx_ready;
            stall_data = txd0;
            if (done0) done_at = c;
            c++;
        end
        check("done_seen", {31'h0, done_at >= 0}, 32'h1);
        check("halt_at", halt_at, 1);
        if (exp_lat >= 0) check("done_lat", done_at - halt_at, exp_lat);
        check("rd_count", nrd, 8);
        check("nbytes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check("frame_byte", (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
        if (exp_csum >= 0)
            check("csum_const", (got_q.size() > 0) ? {24'h0, got_q[got_q.size()-1]} : 32'hFFFF_FFFF, exp_csum);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            instr0   = {25'($urandom), c_ECALL};
            tx_ready = 1'($urandom);
            @(negedge clk);
            check("after_done", {27'h0, halt0, busy0, done0, txv0, rd_en0}, 32'b10100);
        end
    endtask

    typedef struct {
        int kind;
        int mode;
        int hold;
        int csum;
        int lat;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] got_q[$];
        int         nrd, halt_at, done_at, c;
        logic [31:0] w3;

        vecs[0] = '{kind: 0, mode: 0, hold: 1,  csum: 'h14, lat: 50};
        vecs[1] = '{kind: 1, mode: 0, hold: 1,  csum: 'hE4, lat: 50};
        vecs[2] = '{kind: 0, mode: 1, hold: 1,  csum: 'h14, lat: -1};
        vecs[3] = '{kind: 2, mode: 2, hold: 20, csum: -1,   lat: -1};
        vecs[4] = '{kind: 2, mode: 0, hold: 20, csum: -1,   lat: 50};
        vecs[5] = '{kind: 1, mode: 1, hold: 3,  csum: 'hE4, lat: -1};

        for (int v = 0; v < 6; v++) begin
            fill_mem0(vecs[v].kind);
            do_reset();
            run_dump0(vecs[v].mode, vecs[v].hold, vecs[v].csum, vecs[v].lat);
        end

        // Reset while word 3 byte 2 is on the link, then a clean restart.
        fill_mem0(2);
        w3 = mem0[3];
        do_reset();
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            instr0   = (i == 0) ? {25'($urandom), c_ECALL} : 32'h0;
            tx_ready = 1'b1;
            if (i == 24) rst = 1'b1;
            @(negedge clk);
        end
        check("mid_byte", {23'h0, txv0, txd0}, {23'h0, 1'b1, w3[23:16]});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle0("mid_reset");
        run_dump0(0, 1, -1, 50);

        // Address wrap: 3-bit address space, window starting at 6.
        for (int i = 0; i < 8; i++) mem1[i] = $urandom;
        do_reset();
        build_exp(6, 4, 8, 1'b1);
        nrd = 0; done_at = -1; c = 0;
        while (done_at < 0 && c < 500) begin
            @(posedge clk); #1;
            instr1   = (c == 0) ? {25'($urandom), c_ECALL} : 32'h0;
            tx_ready = 1'($urandom);
            @(negedge clk);
            if (rd_en1) begin
                check("wrap_addr", {29'h0, addr1}, (6 + nrd) % 8);
                nrd++;
            end
            if (txv1 && tx_ready) got_q.push_back(txd1);
            if (done1) done_at = c;
            c++;
        end
        check("wrap_done", {31'h0, done_at >= 0}, 32'h1);
        check("wrap_rd_count", nrd, 4);
        check("wrap_nbytes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check("wrap_byte", (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});

        // Empty window: header then a zero checksum, no memory reads.
        do_reset();
        got_q = {};
        nrd = 0; halt_at = -1; done_at = -1; c = 0;
        while (done_at < 0 && c < 100) begin
            @(posedge clk); #1;
            instr2   = (c == 0) ? {25'($urandom), c_ECALL} : $urandom;
            tx_ready = 1'b1;
            @(negedge clk);
            if (halt2 && halt_at < 0) halt_at = c;
            if (rd_en2) nrd++;
            if (txv2 && tx_ready) got_q.push_back(txd2);
            if (done2) done_at = c;
            c++;
        end
        check("empty_done", {31'h0, done_at >= 0}, 32'h1);
        check("empty_lat", done_at - halt_at, 2);
        check("empty_rd_count", nrd, 0);
        check("empty_nbytes", got_q.size(), 2);
        check("empty_frame", (got_q.size() == 2) ? {16'h0, got_q[0], got_q[1]} : 32'hFFFF_FFFF, 32'h0000_A500);
        check("empty_final", {28'h0, halt2, busy2, done2, txv2}, 32'b1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_dump.md
Name: result_dump

Overview:
- Readout side of the program-run flow: watches the instruction stream for ECALL, then freezes the core.
- After the freeze, reads a window of data memory and streams it out as a framed byte stream over a valid/ready link.
- Sits between processor_top (instruction bus and data-memory read port) and a byte-wide host/UART transmitter.
- Replaces hierarchical peeking at data memory with an on-chip result path.

Parameters:
ADDR_WIDTH, 8, data-memory word-address width
START_ADDR, 0, first data-memory word address dumped
NUM_WORDS, 8, number of 32-bit words dumped (0 allowed)
ECALL_OPCODE, 7'b1110011, opcode field value that triggers the dump
HEADER_BYTE, 8'hA5, first byte of every frame

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
instr  in  32  instruction currently fetched by the core
halt  out  1  freezes the core (PC/regfile/dmem write enables) while high
dmem_rd_en  out  1  data-memory read strobe
dmem_rd_addr  out  ADDR_WIDTH  data-memory word address
dmem_rd_data  in  32  read data, valid exactly 1 cycle after dmem_rd_en
tx_data  out  8  outgoing byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte when tx_valid && tx_ready
busy  out  1  high from trigger until frame complete
done  out  1  sticky, frame fully sent

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; halt, dmem_rd_en, tx_valid, busy, done = 0; dmem_rd_addr, tx_data = 0; word index and checksum = 0. Reset applies in any state and aborts a frame mid-byte; no partial-frame recovery.
- Frame format: HEADER_BYTE, then NUM_WORDS words each sent as 4 bytes little-endian (bits 7:0 first), then one checksum byte = XOR of all data bytes (header excluded). Total bytes = 4*NUM_WORDS + 2.
- States and transitions:
  - IDLE: when instr[6:0]==ECALL_OPCODE at edge N, enter HDR. halt, busy = 1 from cycle N+1 (registered). tx_valid=1 with tx_data=HEADER_BYTE at N+1.
  - HDR: hold tx_data/tx_valid until handshake. Then REQ if NUM_WORDS>0, else CSUM.
  - REQ: one cycle; dmem_rd_en=1, dmem_rd_addr = START_ADDR+index, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH); go to WAIT.
  - WAIT: one cycle; capture dmem_rd_data into a 32-bit shift register; go to SEND.
  - SEND: present byte k (k=0..3) with tx_valid=1. On each handshake: XOR the byte into checksum, advance k. After byte 3: index+1; REQ if index < NUM_WORDS, else CSUM.
  - CSUM: present checksum byte; on handshake go to DONE.
  - DONE: tx_valid=0, busy=0, done=1, halt stays 1. Further ECALLs ignored. Exit only via rst.
- dmem_rd_en is high only in REQ; it is 0 in every other state.
- Handshake rules:
  - tx_data must not change while tx_valid && !tx_ready.
  - tx_valid never drops without a handshake, except on rst.
  - tx_ready may be high when tx_valid=0; this has no effect.
- Throughput: with tx_ready held 1, each word costs 6 cycles (REQ, WAIT, 4 SEND). The full frame completes 2 + 6*NUM_WORDS cycles after halt rises.
- ECALL appearing while not in IDLE is ignored; the trigger is edge-of-state, not level.
- instr is sampled only in IDLE. X/garbage on instr outside IDLE must not affect state.
- The checksum register resets to 0 at each trigger.

Test Plan:
- Divide run: dmem[0..7]={0,0,0,0,0,0,0,20}, ECALL at cycle 50, tx_ready=1 -> halt rises cycle 51; bytes A5, then 28 zero bytes, then 14 00 00 00, checksum 0x14; done asserts cycle 51+2+48 = 101.
- Multiply run: dmem[7]=12500 (0x000030D4), others 0 -> word 7 bytes D4 30 00 00; checksum = D4^30 = 0xE4.
- Backpressure: tx_ready toggled 1,0,0,1 repeating -> tx_data stable across every stalled cycle, byte sequence identical to the no-stall case, no dropped or duplicated bytes.
- Wrap and empty: ADDR_WIDTH=3, START_ADDR=6, NUM_WORDS=4 -> reads addresses 6,7,0,1. Separately, NUM_WORDS=0 -> frame A5 00, done after 2 handshakes, dmem_rd_en never high.
- Reset mid-frame: rst=1 for one cycle while in SEND byte 2 of word 3 -> next cycle all outputs 0, state IDLE. A new ECALL restarts a full frame from A5 with checksum from 0.
- Repeat/spurious ECALL: ECALL held on instr for 20 cycles, and again after done -> exactly one frame emitted, done stays 1, halt stays 1.
